dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the 64-byte data memory. It shares the single memory port between the CPU load/store stage (requester 0) and a DMA/debug port (requester 1) using round-robin arbitration. It also checks word alignment and range, stalls while the memory reports `DMemError`, and aborts with an error after a bounded stall. Responses are registered and returned with a one-cycle ack pulse.

---
 rtl/dmem_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-memory port between the CPU (requester 0)
// and a DMA/debug port (requester 1) with round-robin arbitration. It checks
// alignment and range, stalls on DMemError and aborts after a bounded stall.
// Ports:
//   Clk, Rst               clock, synchronous active-low reset
//   req/we/addr/wdata 0,1  requester side, held until ack
//   ack/rdata/err 0,1      one-cycle completion pulse, registered read data, error
//   memRead, memWrite      memory strobes (only in ACCESS, gated by Rst)
//   Address, WriteData     memory address/data (zero outside ACCESS)
//   ReadData, DMemError    memory read data and busy/miss indication
module dmem_arbiter #(
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        req0,
    input  logic        we0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    input  logic        req1,
    input  logic        we1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic [31:0] rdata0,
    output logic        err0,
    output logic        ack1,
    output logic [31:0] rdata1,
    output logic        err1,
    output logic        memRead,
    output logic        memWrite,
    output logic [31:0] Address,
    output logic [31:0] WriteData,
    input  logic [31:0] ReadData,
    input  logic        DMemError
);

    localparam int unsigned CntW    = $clog2(TIMEOUT + 1);
    localparam logic [31:0] BadData = 32'hBAD0DADA;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state, stateNext;
    logic              ptr, ptrNext;        // requester favoured on contention
    logic              gntId, gntIdNext;
    logic              weQ, weNext;
    logic [31:0]       addrQ, addrNext;
    logic [31:0]       wdataQ, wdataNext;
    logic [CntW-1:0]   cnt, cntNext;
    logic [31:0]       rdata0Next, rdata1Next;
    logic              ack0Next, ack1Next, err0Next, err1Next;
    logic              gntSel;
    logic [31:0]       selAddr;

    // Word-aligned and inside the memory's byte range.
    function automatic logic isLegal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && ((a >> ADDR_W) == 32'd0);
    endfunction

    // State and datapath registers.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state  <= IDLE;
            ptr    <= 1'b0;
            gntId  <= 1'b0;
            weQ    <= 1'b0;
            addrQ  <= 32'd0;
            wdataQ <= 32'd0;
            cnt    <= '0;
            rdata0 <= 32'd0;
            rdata1 <= 32'd0;
            ack0   <= 1'b0;
            ack1   <= 1'b0;
            err0   <= 1'b0;
            err1   <= 1'b0;
        end else begin
            state  <= stateNext;
            ptr    <= ptrNext;
            gntId  <= gntIdNext;
            weQ    <= weNext;
            addrQ  <= addrNext;
            wdataQ <= wdataNext;
            cnt    <= cntNext;
            rdata0 <= rdata0Next;
            rdata1 <= rdata1Next;
            ack0   <= ack0Next;
            ack1   <= ack1Next;
            err0   <= err0Next;
            err1   <= err1Next;
        end
    end

    // Next-state, register updates and memory-side strobes.
    always_comb begin
        stateNext  = state;
        ptrNext    = ptr;
        gntIdNext  = gntId;
        weNext     = weQ;
        addrNext   = addrQ;
        wdataNext  = wdataQ;
        cntNext    = cnt;
        rdata0Next = rdata0;
        rdata1Next = rdata1;
        ack0Next   = 1'b0;
        ack1Next   = 1'b0;
        err0Next   = 1'b0;
        err1Next   = 1'b0;
        gntSel     = 1'b0;
        selAddr    = 32'd0;
        memRead    = 1'b0;
        memWrite   = 1'b0;
        Address    = 32'd0;
        WriteData  = 32'd0;

        unique case (state)
            IDLE: begin
                if (req0 || req1) begin
                    gntSel    = (req0 && req1) ? ptr : req1;
                    selAddr   = gntSel ? addr1 : addr0;
                    gntIdNext = gntSel;
                    ptrNext   = ~gntSel;
                    weNext    = gntSel ? we1 : we0;
                    addrNext  = selAddr;
                    wdataNext = gntSel ? wdata1 : wdata0;
                    cntNext   = '0;
                    if (isLegal(selAddr)) begin
                        stateNext = ACCESS;
                    end else begin
                        // Skip the memory entirely; rdata is left alone.
                        stateNext = DONE;
                        ack0Next  = ~gntSel;
                        ack1Next  = gntSel;
                        err0Next  = ~gntSel;
                        err1Next  = gntSel;
                    end
                end
            end

            ACCESS: begin
                // Strobes are gated by Rst so a reset cycle never commits a write.
                memRead   = ~weQ & Rst;
                memWrite  = weQ & ~DMemError & Rst;
                Address   = addrQ;
                WriteData = wdataQ;
                if (!DMemError) begin
                    stateNext = DONE;
                    ack0Next  = ~gntId;
                    ack1Next  = gntId;
                    if (!weQ) begin
                        if (gntId) rdata1Next = ReadData;
                        else       rdata0Next = ReadData;
                    end
                end else if (cnt == CntW'(TIMEOUT)) begin
                    stateNext = DONE;
                    ack0Next  = ~gntId;
                    ack1Next  = gntId;
                    err0Next  = ~gntId;
                    err1Next  = gntId;
                    if (!weQ) begin
                        if (gntId) rdata1Next = BadData;
                        else       rdata0Next = BadData;
                    end
                end else begin
                    cntNext = cnt + CntW'(1);
                end
            end

            DONE: begin
                stateNext = IDLE;
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a 16-word memory model.
module tb_dmem_arbiter;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic        ack0, err0, ack1, err1;
    logic [31:0] rdata0, rdata1;
    logic        memRead, memWrite;
    logic [31:0] Address, WriteData, ReadData;
    logic        DMemError;

    int errors = 0;
    int checks = 0;
    int wrPulses = 0;
    int wrBase;

    // Memory model with a bench-side poke port.
    logic [31:0] mem [16];
    logic        tbWe;
    logic [3:0]  tbIdx;
    logic [31:0] tbData;

    always #5 Clk = ~Clk;

    assign ReadData = mem[Address[5:2]];

    always @(posedge Clk) begin
        if (tbWe)          mem[tbIdx] <= tbData;
        else if (memWrite) mem[Address[5:2]] <= WriteData;
    end

    always @(negedge Clk) begin
        if (memWrite) wrPulses <= wrPulses + 1;
    end

    dmem_arbiter #(.ADDR_W(6), .TIMEOUT(15)) dut (
        .Clk(Clk), .Rst(Rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack0(ack0), .rdata0(rdata0), .err0(err0),
        .ack1(ack1), .rdata1(rdata1), .err1(err1),
        .memRead(memRead), .memWrite(memWrite),
        .Address(Address), .WriteData(WriteData),
        .ReadData(ReadData), .DMemError(DMemError)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [3:0] idx, input logic [31:0] data);
        tbWe = 1'b1; tbIdx = idx; tbData = data;
        tick();
        tbWe = 1'b0;
    endtask

    initial begin
        Rst = 1'b0; DMemError = 1'b0; tbWe = 1'b0; tbIdx = 4'd0; tbData = 32'd0;
        req0 = 1'b0; we0 = 1'b0; addr0 = 32'd0; wdata0 = 32'd0;
        req1 = 1'b0; we1 = 1'b0; addr1 = 32'd0; wdata1 = 32'd0;
        for (int i = 0; i < 16; i++) poke(4'(i), 32'd0);
        poke(4'd2, 32'h11223344);

        // Reset values
        chk1("rst_ack0", ack0, 1'b0);
        chk1("rst_ack1", ack1, 1'b0);
        chk1("rst_err0", err0, 1'b0);
        chk1("rst_err1", err1, 1'b0);
        chk32("rst_rdata0", rdata0, 32'h0);
        chk32("rst_rdata1", rdata1, 32'h0);
        chk1("rst_memRead", memRead, 1'b0);
        chk1("rst_memWrite", memWrite, 1'b0);
        chk32("rst_Address", Address, 32'h0);
        chk32("rst_WriteData", WriteData, 32'h0);
        Rst = 1'b1;
        tick();

        // Single read at address 8
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd8;
        chk1("rd_idle_memRead", memRead, 1'b0);
        tick();
        chk1("rd_acc_memRead", memRead, 1'b1);
        chk32("rd_acc_Address", Address, 32'd8);
        chk1("rd_acc_ack0", ack0, 1'b0);
        tick();
        chk1("rd_done_ack0", ack0, 1'b1);
        chk32("rd_done_rdata0", rdata0, 32'h11223344);
        chk1("rd_done_err0", err0, 1'b0);
        chk1("rd_done_memRead", memRead, 1'b0);
        req0 = 1'b0;
        tick();
        chk1("rd_idle_ack0", ack0, 1'b0);

        // Write 0xDEADBEEF at 20 via port 1, then read it back
        wrBase = wrPulses;
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'd20; wdata1 = 32'hDEADBEEF;
        tick();
        chk1("wr_acc_memWrite", memWrite, 1'b1);
        chk32("wr_acc_WriteData", WriteData, 32'hDEADBEEF);
        tick();
        chk1("wr_done_ack1", ack1, 1'b1);
        chk1("wr_done_err1", err1, 1'b0);
        chk32("wr_mem5", mem[5], 32'hDEADBEEF);
        req1 = 1'b0;
        tick();
        chk32("wr_pulses", 32'(wrPulses - wrBase), 32'd1);
        req1 = 1'b1; we1 = 1'b0;
        tick();
        tick();
        chk1("rb_ack1", ack1, 1'b1);
        chk32("rb_rdata1", rdata1, 32'hDEADBEEF);
        req1 = 1'b0;
        tick();

        // Contention: both held for four transactions, grants 0,1,0,1
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd8;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'd20;
        for (int c = 1; c <= 11; c++) begin
            tick();
            chk1("ct_ack0", ack0, (c == 2 || c == 8));
            chk1("ct_ack1", ack1, (c == 5 || c == 11));
            chk1("ct_both", ack0 & ack1, 1'b0);
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();

        // Misaligned read at 6, out-of-range write at 64
        wrBase = wrPulses;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd6;
        tick();
        chk1("al_ack0", ack0, 1'b1);
        chk1("al_err0", err0, 1'b1);
        chk1("al_memRead", memRead, 1'b0);
        chk32("al_rdata0", rdata0, 32'h11223344);
        req0 = 1'b0;
        tick();
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'd64; wdata0 = 32'h0BADF00D;
        tick();
        chk1("rg_ack0", ack0, 1'b1);
        chk1("rg_err0", err0, 1'b1);
        chk1("rg_memWrite", memWrite, 1'b0);
        chk32("rg_rdata0", rdata0, 32'h11223344);
        req0 = 1'b0;
        tick();
        chk32("rg_pulses", 32'(wrPulses - wrBase), 32'd0);

        // Three stall cycles on a read
        poke(4'd2, 32'hCAFEF00D);
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd8;
        tick();
        DMemError = 1'b1;
        tick();
        tick();
        tick();
        DMemError = 1'b0;
        chk1("st_ack0_early", ack0, 1'b0);
        tick();
        chk1("st_ack0", ack0, 1'b1);
        chk1("st_err0", err0, 1'b0);
        chk32("st_rdata0", rdata0, 32'hCAFEF00D);
        req0 = 1'b0;
        tick();

        // Read timeout: ack at N+17 with error data
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd8; DMemError = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk1("to_ack0_wait", ack0, 1'b0);
        end
        tick();
        chk1("to_ack0", ack0, 1'b1);
        chk1("to_err0", err0, 1'b1);
        chk32("to_rdata0", rdata0, 32'hBAD0DADA);
        req0 = 1'b0; DMemError = 1'b0;
        tick();

        // Write under a held error never strobes memWrite
        wrBase = wrPulses;
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'd12; wdata1 = 32'h12345678; DMemError = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk1("tw_memWrite", memWrite, 1'b0);
        end
        tick();
        chk1("tw_ack1", ack1, 1'b1);
        chk1("tw_err1", err1, 1'b1);
        chk32("tw_mem3", mem[3], 32'h0);
        chk32("tw_pulses", 32'(wrPulses - wrBase), 32'd0);
        req1 = 1'b0; DMemError = 1'b0;
        tick();

        // Reset during ACCESS of a write
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'd16; wdata0 = 32'hAAAA5555;
        tick();
        chk1("ra_memWrite_pre", memWrite, 1'b1);
        Rst = 1'b0;
        #1;
        chk1("ra_memWrite", memWrite, 1'b0);
        chk1("ra_memRead", memRead, 1'b0);
        tick();
        chk1("ra_ack0", ack0, 1'b0);
        chk32("ra_rdata0", rdata0, 32'h0);
        chk32("ra_rdata1", rdata1, 32'h0);
        chk32("ra_Address", Address, 32'h0);
        chk32("ra_mem4", mem[4], 32'h0);
        Rst = 1'b1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd8;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'd20;
        tick();
        chk32("ra_acc_Address", Address, 32'd8);
        tick();
        chk1("ra_gnt_ack0", ack0, 1'b1);
        chk1("ra_gnt_ack1", ack1, 1'b0);
        chk32("ra_gnt_rdata0", rdata0, 32'hCAFEF00D);
        req0 = 1'b0; req1 = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
